debounce_pwm_quartsine: RTL and testbench
=========================================

// Module: debounce_pwm_quartsine
// PURPOSE
//  Audio front-end for the arpeggiator board design: debounces a push button,
//  converts an 8-bit phase address into an 11-bit sine sample from a quarter-wave
//  table, and drives a single-bit PWM audio output.
//  Sits between the note-sequencing logic (which owns the phase address and the
//  arp toggle) and the AUD_PWM pin.
// PARAMETERS
//  DB_CYCLES  1_000_000  stable cycles required before btn_db changes (10 ms at 100 MHz); >=2
//  ADDR_W     8          phase address width; fixed, 256 samples per period
//  PWM_W      11         sample width and PWM counter width; fixed
// PORTS
//  clk       in   1   system clock (100 MHz); the block's only clock
//  rst       in   1   synchronous, active-high reset
//  btn_in    in   1   raw asynchronous push button
//  btn_db    out  1   debounced button level
//  addr      in   8   sine phase address, 0..255 covers one period
//  sine_out  out  11  offset-binary sine sample, registered
//  pwm_in    in   11  duty value for the PWM
//  pwm_out   out  1   PWM audio bit (to AUD_PWM)
// BEHAVIOUR
//  Reset, on the clk edge while rst=1:
//   - btn_db=0, debounce counter=0, both synchronizer flops=0
//   - sine_out=1024
//   - PWM counter=0, latched duty=0, pwm_out=0
//  Debounce:
//   - btn_in passes through a 2-flop synchronizer to give s.
//   - If s==btn_db, the counter clears.
//   - Otherwise the counter increments. When it reaches DB_CYCLES-1, btn_db<=s
//     and the counter clears.
//   - A single mismatch-free cycle restarts the count, so glitches shorter than
//     DB_CYCLES never reach btn_db.
//   - Total latency from a clean edge on btn_in to btn_db is DB_CYCLES+2 cycles.
//  Sine:
//   - Quarter table Q[k]=round(1023*sin(pi*k/128)) for k=0..64.
//     Q[0]=0, Q[32]=723, Q[64]=1023.
//   - Split addr into q=addr[7:6] and i=addr[5:0].
//   - Define m = Q[i] when q is even, m = Q[64-i] when q is odd.
//   - sine_out = 1024+m for q<2, and 1024-m for q>=2.
//   - Output range is 1..2047. sine_out is registered with 1-cycle latency
//     from addr (BRAM-like).
//   - Wrap: addr 255 -> 0 is seamless. addr=255 gives 1024-Q[1], which is 999.
//  PWM:
//   - An 11-bit counter increments every clk and wraps 2047->0, giving a
//     2048-cycle period.
//   - pwm_in is latched into duty when the counter is 2047, so the new duty
//     applies from the counter=0 cycle. This keeps pulses glitch-free.
//   - pwm_out is registered: pwm_out <= (next_counter < duty).
//   - High time per period = duty cycles. duty=0 holds pwm_out low.
//     duty=2047 gives one low cycle per period.
//  Reset mid-operation: every state returns to the reset values above on the
//   next edge. There is no partial-state carry-over.
// STRUCTURE
//  - Shared package: SINE_MID=1024, SINE_AMP=1023, ADDR_W, PWM_W, and the
//    65-entry quarter-table constant or function.
//  - One natural sub-module: quarter_sine_rom (addr -> registered sample).
//  - Debounce and PWM stay inline as two always blocks.
// TESTING
//  - Reset: assert rst for 3 cycles with random inputs.
//    -> btn_db=0, sine_out=1024, pwm_out=0.
//  - Sine sweep: addr 0..255, one per cycle.
//    -> next-cycle sine_out of 1024 at 0, 1747 at 32, 2047 at 64, 1024 at 128,
//       1 at 192, 999 at 255. All 256 values match the golden model.
//  - PWM duty: pwm_in=512, held for 4 periods.
//    -> exactly 512 high cycles per 2048.
//    pwm_in=0 -> pwm_out is never high. pwm_in=2047 -> 2047 high cycles per period.
//  - PWM mid-period change: pwm_in 300->1500 at counter=1000.
//    -> the current period has 300 high cycles; the next period has 1500.
//  - Debounce, with DB_CYCLES=16: hold btn_in=1.
//    -> btn_db rises exactly 18 cycles after the edge.
//    15-cycle pulses -> btn_db stays 0. Bounce 1/0/1 then steady 1 -> one rise.
//  - Reset during a debounce count (counter=10) -> btn_db=0 and the count
//    restarts from 0.

Source files
------------

// File: rtl/debounce_pwm_quartsine_pkg.sv
// Shared constants and the quarter-wave sine table for the audio front-end.
// Table entries are round(1023*sin(pi*k/128)) for k = 0..64.
package debounce_pwm_quartsine_pkg;

    localparam int ADDR_W   = 8;
    localparam int PWM_W    = 11;
    localparam int SINE_MID = 1024;
    localparam int SINE_AMP = 1023;
    localparam int Q_W      = $clog2(SINE_AMP + 1);
    localparam int Q_LAST   = 64;

    typedef logic [Q_W-1:0] qsample_t;

    localparam qsample_t QUARTER_TAB [0:Q_LAST] = '{
        10'd0,    10'd25,   10'd50,   10'd75,   10'd100,  10'd125,  10'd150,  10'd175,
        10'd200,  10'd224,  10'd249,  10'd273,  10'd297,  10'd321,  10'd345,  10'd368,
        10'd391,  10'd415,  10'd437,  10'd460,  10'd482,  10'd504,  10'd526,  10'd547,
        10'd568,  10'd589,  10'd609,  10'd629,  10'd649,  10'd668,  10'd687,  10'd705,
        10'd723,  10'd741,  10'd758,  10'd775,  10'd791,  10'd806,  10'd822,  10'd836,
        10'd851,  10'd864,  10'd877,  10'd890,  10'd902,  10'd914,  10'd925,  10'd935,
        10'd945,  10'd954,  10'd963,  10'd971,  10'd979,  10'd986,  10'd992,  10'd998,
        10'd1003, 10'd1008, 10'd1012, 10'd1015, 10'd1018, 10'd1020, 10'd1022, 10'd1023,
        10'd1023
    };

    function automatic qsample_t quarter_q(input logic [6:0] k);
        return (k > 7'(Q_LAST)) ? '0 : QUARTER_TAB[k];
    endfunction

endpackage

// File: rtl/debounce_pwm_quartsine_if.sv
// Signal bundle between the note-sequencing logic (master) and the audio front-end (slave).
interface debounce_pwm_quartsine_if;
    import debounce_pwm_quartsine_pkg::*;

    logic              btn_in;
    logic              btn_db;
    logic [ADDR_W-1:0] addr;
    logic [PWM_W-1:0]  sine_out;
    logic [PWM_W-1:0]  pwm_in;
    logic              pwm_out;

    modport master (
        output btn_in, addr, pwm_in,
        input  btn_db, sine_out, pwm_out
    );

    modport slave (
        input  btn_in, addr, pwm_in,
        output btn_db, sine_out, pwm_out
    );

endinterface

// File: rtl/debounce_pwm_quartsine_quarter_sine_rom.sv
// Phase address to offset-binary sine sample, folded from a quarter-wave table.
// One register stage after the lookup so it behaves like a block RAM read.
module quarter_sine_rom
    import debounce_pwm_quartsine_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    output logic [PWM_W-1:0]  sample
);

    logic [1:0]       quad;
    logic [5:0]       idx;
    logic [6:0]       k;
    qsample_t         m;
    logic [PWM_W-1:0] sample_d;

    // Odd quadrants read the table backwards; the upper half-period is mirrored below mid-scale.
    always_comb begin
        quad     = addr[ADDR_W-1 -: 2];
        idx      = addr[5:0];
        k        = quad[0] ? (7'(Q_LAST) - {1'b0, idx}) : {1'b0, idx};
        m        = quarter_q(k);
        sample_d = quad[1] ? (PWM_W'(SINE_MID) - PWM_W'(m))
                           : (PWM_W'(SINE_MID) + PWM_W'(m));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sample <= PWM_W'(SINE_MID);
        end else begin
            sample <= sample_d;
        end
    end

endmodule

// File: rtl/debounce_pwm_quartsine.sv
// Audio front-end: button debouncer, quarter-wave sine lookup and single-bit PWM output.
module debounce_pwm_quartsine
    import debounce_pwm_quartsine_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
)
(
    input  logic                    clk,
    input  logic                    rst,
    debounce_pwm_quartsine_if.slave bus
);

    localparam int DB_W = $clog2(DB_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [PWM_W-1:0] PWM_LAST = '1;

    logic [1:0]       sync_q;
    logic [DB_W-1:0]  db_cnt;
    logic             btn_db_q;
    logic [PWM_W-1:0] sine_q;
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] cnt_next;
    logic [PWM_W-1:0] duty_next;
    logic             pwm_q;

    // Any cycle where the synchronized level agrees with btn_db restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= 2'b00;
            db_cnt   <= '0;
            btn_db_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], bus.btn_in};
            if (sync_q[1] == btn_db_q) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                btn_db_q <= sync_q[1];
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    quarter_sine_rom u_rom (
        .clk    (clk),
        .rst    (rst),
        .addr   (bus.addr),
        .sample (sine_q)
    );

    // Duty only changes at the period boundary so a pulse is never cut short or stretched.
    always_comb begin
        cnt_next  = pwm_cnt + 1'b1;
        duty_next = (pwm_cnt == PWM_LAST) ? bus.pwm_in : duty;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_cnt <= cnt_next;
            duty    <= duty_next;
            pwm_q   <= (cnt_next < duty_next);
        end
    end

    assign bus.btn_db   = btn_db_q;
    assign bus.sine_out = sine_q;
    assign bus.pwm_out  = pwm_q;

endmodule

// File: tb/tb_debounce_pwm_quartsine.sv
// Self-checking bench for the audio front-end, run with a short debounce window.
module tb_debounce_pwm_quartsine;
    import debounce_pwm_quartsine_pkg::*;

    localparam int DB = 16;
    localparam int PERIOD = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    debounce_pwm_quartsine_if dif ();

    debounce_pwm_quartsine #(.DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    always #5 clk = ~clk;

    // cyc mirrors cycles since the last reset edge, so (cyc % PERIOD) is the PWM phase.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) cyc = 0;
        else     cyc++;
    endtask

    function automatic int golden_sine(input int a);
        real r;
        real v;
        r = 1023.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 256.0);
        if (r >= 0.0) v = $floor(r + 0.5);
        else          v = -$floor(-r + 0.5);
        return 1024 + $rtoi(v);
    endfunction

    task automatic align_period();
        while ((cyc % PERIOD) != PERIOD - 1) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            dif.btn_in = 1'($urandom);
            dif.addr   = 8'($urandom);
            dif.pwm_in = 11'($urandom);
            tick();
        end
        vectors++;
        if (dif.btn_db !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_btn_db got %0b want 0", dif.btn_db);
        end
        vectors++;
        if (dif.sine_out !== 11'd1024) begin
            miscompares++;
            $display("FAIL reset_sine got %0d want 1024", dif.sine_out);
        end
        vectors++;
        if (dif.pwm_out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_pwm got %0b want 0", dif.pwm_out);
        end
        dif.btn_in = 1'b0;
        dif.addr   = '0;
        dif.pwm_in = '0;
        rst        = 1'b0;
    endtask

    task automatic test_sine_sweep();
        int spot_a [6] = '{0, 32, 64, 128, 192, 255};
        int spot_v [6] = '{1024, 1747, 2047, 1024, 1, 999};
        for (int a = 0; a < 256; a++) begin
            dif.addr = 8'(a);
            tick();
            vectors++;
            if (dif.sine_out !== 11'(golden_sine(a))) begin
                miscompares++;
                $display("FAIL sine_sweep addr=%0d got %0d want %0d", a, dif.sine_out, golden_sine(a));
            end
            for (int s = 0; s < 6; s++) begin
                if (spot_a[s] == a) begin
                    vectors++;
                    if (dif.sine_out !== 11'(spot_v[s])) begin
                        miscompares++;
                        $display("FAIL sine_spot addr=%0d got %0d want %0d", a, dif.sine_out, spot_v[s]);
                    end
                end
            end
        end
        // wrap back to 0 right after 255
        dif.addr = 8'd0;
        tick();
        vectors++;
        if (dif.sine_out !== 11'd1024) begin
            miscompares++;
            $display("FAIL sine_wrap got %0d want 1024", dif.sine_out);
        end
    endtask

    task automatic test_sine_random();
        int a;
        repeat (300) begin
            a = int'($urandom_range(0, 255));
            dif.addr = 8'(a);
            tick();
            vectors++;
            if (dif.sine_out !== 11'(golden_sine(a))) begin
                miscompares++;
                $display("FAIL sine_random addr=%0d got %0d want %0d", a, dif.sine_out, golden_sine(a));
            end
        end
    endtask

    task automatic test_pwm_duty(input int d, input int periods, input bit per_cycle);
        int hi;
        align_period();
        dif.pwm_in = 11'(d);
        for (int p = 0; p < periods; p++) begin
            hi = 0;
            repeat (PERIOD) begin
                tick();
                if (dif.pwm_out === 1'b1) hi++;
                if (per_cycle) begin
                    vectors++;
                    if (dif.pwm_out !== 1'(((cyc % PERIOD) < d) ? 1 : 0)) begin
                        miscompares++;
                        $display("FAIL pwm_cycle duty=%0d phase=%0d got %0b", d, cyc % PERIOD, dif.pwm_out);
                    end
                end
            end
            vectors++;
            if (hi != d) begin
                miscompares++;
                $display("FAIL pwm_duty duty=%0d period=%0d high=%0d want %0d", d, p, hi, d);
            end
        end
    endtask

    task automatic test_pwm_mid_change();
        int hi;
        align_period();
        dif.pwm_in = 11'd300;
        hi = 0;
        repeat (PERIOD) begin
            tick();
            if (dif.pwm_out === 1'b1) hi++;
            if ((cyc % PERIOD) == 1000) dif.pwm_in = 11'd1500;
        end
        vectors++;
        if (hi != 300) begin
            miscompares++;
            $display("FAIL pwm_mid_current high=%0d want 300", hi);
        end
        hi = 0;
        repeat (PERIOD) begin
            tick();
            if (dif.pwm_out === 1'b1) hi++;
        end
        vectors++;
        if (hi != 1500) begin
            miscompares++;
            $display("FAIL pwm_mid_next high=%0d want 1500", hi);
        end
        dif.pwm_in = '0;
    endtask

    task automatic test_debounce_edge();
        int n;
        dif.btn_in = 1'b1;
        n = 0;
        while (dif.btn_db !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != DB + 2) begin
            miscompares++;
            $display("FAIL db_rise_latency got %0d want %0d", n, DB + 2);
        end
        dif.btn_in = 1'b0;
        n = 0;
        while (dif.btn_db !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != DB + 2) begin
            miscompares++;
            $display("FAIL db_fall_latency got %0d want %0d", n, DB + 2);
        end
    endtask

    task automatic test_glitches();
        int hlen;
        int llen;
        for (int p = 0; p < 13; p++) begin
            hlen = (p < 3) ? DB - 1 : int'($urandom_range(1, DB - 1));
            llen = (p < 3) ? 5 : int'($urandom_range(1, 6));
            dif.btn_in = 1'b1;
            repeat (hlen) begin
                tick();
                vectors++;
                if (dif.btn_db !== 1'b0) begin
                    miscompares++;
                    $display("FAIL db_glitch pulse=%0d len=%0d got %0b want 0", p, hlen, dif.btn_db);
                end
            end
            dif.btn_in = 1'b0;
            repeat (llen) begin
                tick();
                vectors++;
                if (dif.btn_db !== 1'b0) begin
                    miscompares++;
                    $display("FAIL db_glitch_gap pulse=%0d got %0b want 0", p, dif.btn_db);
                end
            end
        end
        repeat (4) tick();
    endtask

    task automatic test_bounce();
        int pat_v [4] = '{1, 0, 1, 0};
        int pat_n [4] = '{3, 2, 4, 1};
        int rises;
        int rise_at;
        logic prev;
        rises   = 0;
        rise_at = -1;
        prev    = dif.btn_db;
        for (int s = 0; s < 4; s++) begin
            dif.btn_in = 1'(pat_v[s]);
            repeat (pat_n[s]) begin
                tick();
                if (prev === 1'b0 && dif.btn_db === 1'b1) rises++;
                prev = dif.btn_db;
            end
        end
        dif.btn_in = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (prev === 1'b0 && dif.btn_db === 1'b1) begin
                rises++;
                rise_at = n;
            end
            prev = dif.btn_db;
        end
        vectors++;
        if (rises != 1) begin
            miscompares++;
            $display("FAIL db_bounce_rises got %0d want 1", rises);
        end
        vectors++;
        if (rise_at != DB + 2) begin
            miscompares++;
            $display("FAIL db_bounce_latency got %0d want %0d", rise_at, DB + 2);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int n;
        dif.btn_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dif.btn_in = 1'b1;
        repeat (12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (dif.btn_db !== 1'b0 || dif.sine_out !== 11'd1024 || dif.pwm_out !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_state btn_db=%0b sine=%0d pwm=%0b want 0/1024/0",
                     dif.btn_db, dif.sine_out, dif.pwm_out);
        end
        n = 0;
        while (dif.btn_db !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != DB + 2) begin
            miscompares++;
            $display("FAIL mid_reset_restart got %0d want %0d", n, DB + 2);
        end
    endtask

    initial begin
        dif.btn_in = 1'b0;
        dif.addr   = '0;
        dif.pwm_in = '0;
        test_reset();
        test_sine_sweep();
        test_sine_random();
        test_pwm_duty(512, 4, 1'b0);
        test_pwm_duty(0, 1, 1'b1);
        test_pwm_duty(2047, 1, 1'b1);
        test_pwm_duty(int'($urandom_range(1, 2046)), 2, 1'b1);
        test_pwm_mid_change();
        test_debounce_edge();
        test_glitches();
        test_bounce();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
